alu_result_tx: RTL

- UART-style serial transmitter for the ALU result; the outbound counterpart of the switch/button operand-load path.
- Captures an NB_DATA-bit result on a start pulse and shifts it out on a single line as an 8N1-style frame.
- Sits between the ALU output and the board TX pin; a top level pulses i_start whenever a result is to be reported.

---
 rtl/alu_uart_pkg.sv | 20 ++
 rtl/alu_result_tx_baud_tick_gen.sv | 32 +++
 rtl/alu_result_tx.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/alu_uart_pkg.sv
// Shared UART definitions for the ALU result transmitter and its future receiver.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam logic LINE_IDLE = 1'b1;

    localparam int CLK_HZ               = 50_000_000;
    localparam int BAUD_RATE            = 9600;
    localparam int DEFAULT_CLKS_PER_BIT = CLK_HZ / BAUD_RATE;

endpackage

// File: rtl/alu_result_tx_baud_tick_gen.sv
// Bit-period timer: pulses o_tick on the last clk cycle of every serial bit.
// Latency: o_tick is combinational from the counter; the first tick comes CLKS_PER_BIT-1 cycles after clear.
// Backpressure: none; i_clear holds the counter at zero.
module baud_tick_gen
    import alu_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic i_reset,
    input  logic i_clear,
    output logic o_tick
);

    localparam int NB_CNT = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(CLKS_PER_BIT - 1);

    logic [NB_CNT-1:0] cnt;

    always_ff @(posedge clk) begin
        if (i_reset || i_clear) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + NB_CNT'(1);
        end
    end

    assign o_tick = (cnt == CNT_LAST);

endmodule

// File: rtl/alu_result_tx.sv
// 8N1-style serial transmitter for the ALU result; ALU_TX_PARITY_EN adds an even-parity bit.
// Latency: o_tx/o_busy change the cycle after i_start is sampled; frame is (1+NB_DATA+NB_STOP)*CLKS_PER_BIT cycles.
// Backpressure: i_start while busy is dropped (not queued); a start in the o_done cycle is accepted.
module alu_result_tx
    import alu_uart_pkg::*;
#(
    parameter int NB_DATA      = 8,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int NB_STOP      = 1
) (
    input  logic               clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [NB_DATA-1:0] i_data,
    output logic               o_tx,
    output logic               o_busy,
    output logic               o_done
);

    // One counter serves both the data-bit index and the stop-bit index.
    localparam int BIT_MAX = (NB_DATA > 2) ? NB_DATA : 2;
    localparam int NB_BIT  = $clog2(BIT_MAX);
    localparam logic [NB_BIT-1:0] LAST_DATA = NB_BIT'(NB_DATA - 1);
    localparam logic [NB_BIT-1:0] LAST_STOP = NB_BIT'(NB_STOP - 1);

    tx_state_t          state_q;
    tx_state_t          state_d;
    logic [NB_DATA-1:0] shreg_q;
    logic [NB_DATA-1:0] shreg_d;
    logic [NB_BIT-1:0]  bit_q;
    logic [NB_BIT-1:0]  bit_d;
    logic               tick;
    logic               accept;
    logic               tx_d;
    logic               busy_d;
    logic               done_d;
`ifdef ALU_TX_PARITY_EN
    logic               parity_q;
`endif

    assign accept = (state_q == ST_IDLE) && i_start;

    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .i_reset (i_reset),
        .i_clear (state_q == ST_IDLE),
        .o_tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            bit_q   <= '0;
            o_tx    <= LINE_IDLE;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
`ifdef ALU_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bit_q   <= bit_d;
            o_tx    <= tx_d;
            o_busy  <= busy_d;
            o_done  <= done_d;
`ifdef ALU_TX_PARITY_EN
            if (accept) begin
                parity_q <= ^i_data;
            end
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bit_d   = bit_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_START;
                    shreg_d = i_data;
                    bit_d   = '0;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d = ST_DATA;
                    bit_d   = '0;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_q == LAST_DATA) begin
`ifdef ALU_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                        bit_d = '0;
                    end else begin
                        bit_d = bit_q + NB_BIT'(1);
                    end
                end
            end
`ifdef ALU_TX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    state_d = ST_STOP;
                    bit_d   = '0;
                end
            end
`endif
            ST_STOP: begin
                if (tick) begin
                    if (bit_q == LAST_STOP) begin
                        state_d = ST_IDLE;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + NB_BIT'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                bit_d   = '0;
            end
        endcase
    end

    // Outputs are registered, so they are decoded from the state being entered.
    always_comb begin
        tx_d   = LINE_IDLE;
        busy_d = (state_d != ST_IDLE);
        done_d = (state_q == ST_STOP) && (state_d == ST_IDLE);
        unique case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shreg_d[0];
`ifdef ALU_TX_PARITY_EN
            ST_PARITY: tx_d = parity_q;
`endif
            default:  tx_d = LINE_IDLE;
        endcase
    end

endmodule
